header_stripper: RTL
====================

Name: header_stripper

Overview:
Receive-side counterpart of header_adder; sits directly downstream of it, or at the far end of a link it feeds. Consumes an Avalon-ST packet whose first HEADER_SIZE bits are a header. Extracts the header to a parallel output with a one-cycle valid strobe. Forwards the remaining payload as a new packet, re-generating sop on the first payload beat, through a one-entry registered output stage.

Parameters:
DATA_WIDTH, 8, beat width in bits of data_in/data_out.
HEADER_SIZE, 16, header width in bits; must be a multiple of DATA_WIDTH (elaboration-time $error otherwise).

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
data_in  avalon_st_if slave  DATA_WIDTH  incoming packet (valid, ready, sop, eop, data).
header_data  output  HEADER_SIZE  extracted header; held until the next header completes.
header_vld  output  1  one-cycle pulse when header_data is updated.
data_out  avalon_st_if master  DATA_WIDTH  payload packet.
err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset values: header_data=0, header_vld=0, err=0, data_out.valid/sop/eop=0, data_out.data=0, state=S_WAIT_SOP, beat count=0.
- Reset is asynchronous and active-low; all flops clear immediately; a packet in flight is discarded.
- HDR_BEATS = HEADER_SIZE/DATA_WIDTH.
- A beat is accepted when data_in.valid && data_in.ready.
- Header byte order: the first header beat goes to header_data[HEADER_SIZE-1 -: DATA_WIDTH], the last to bits [DATA_WIDTH-1:0].
- Output stage: single registered entry.
  - data_in.ready = 1 in S_WAIT_SOP and S_HDR.
  - In S_PAYLOAD, data_in.ready = !data_out.valid || data_out.ready.
  - Payload latency is 1 cycle from acceptance to data_out.valid.
  - The output entry holds stable while data_out.valid && !data_out.ready.
- States:
  - S_WAIT_SOP:
    - Accepted beat with sop: load header slice 0, cnt=1.
    - If HDR_BEATS==1, complete the header (see below); otherwise go to S_HDR.
    - Accepted beat without sop: dropped, err pulse.
  - S_HDR:
    - Accepted beat: load slice cnt, cnt++.
    - On the last header beat: header_vld pulses the next cycle with the full header.
      - eop on that beat: header-only packet, nothing forwarded, go to S_WAIT_SOP.
      - Otherwise go to S_PAYLOAD with first_flag=1.
    - eop before the last header beat: short packet; err pulse, header_vld stays 0, header_data unchanged, go to S_WAIT_SOP.
  - S_PAYLOAD:
    - Accepted beat is forwarded with data_out.sop=first_flag and data_out.eop=data_in.eop, then first_flag clears.
    - Forwarded beat with eop: go to S_WAIT_SOP.
- Framing errors:
  - sop accepted in S_HDR: err pulse, restart header collection with this beat as slice 0.
  - sop accepted in S_PAYLOAD: err pulse, restart header collection with this beat as slice 0, not forwarded. The truncated output packet is left without eop; downstream must tolerate this.
- HEADER_SIZE==DATA_WIDTH: the header is exactly the sop beat; behaviour is identical otherwise.
- Output stall: while the output entry is blocked, nothing is lost, data_in.ready=0, and the state machine holds.
- Back-to-back packets: a new sop may be accepted the cycle after the previous eop was accepted.

Decomposition:
- Package header_pkg holds:
  - the enum hdr_state_e {S_WAIT_SOP, S_HDR, S_PAYLOAD};
  - the function hdr_beats(HEADER_SIZE, DATA_WIDTH), shared with header_adder.
- Beat counter width: $clog2(HDR_BEATS+1).
- One natural sub-module: avalon_st_reg_slice, a one-entry registered Avalon-ST stage, parameterised by DATA_WIDTH, used for the output entry.

Test Plan:
- Config 8/16, out.ready=1; packet of 5 beats 0xAB,0xCD,0x01,0x02,0x03 (sop on 0xAB, eop on 0x03).
  -> header_vld one pulse with header_data=0xABCD.
  -> data_out emits 0x01(sop), 0x02, 0x03(eop), each 1 cycle after input acceptance; err=0.
- Config 16/16; packet 0xFFFF(sop), 0x0000..0x0008 (eop on 0x0008).
  -> header_data=0xFFFF.
  -> data_out carries 9 beats with sop on 0x0000 and eop on 0x0008.
- Config 8/16; 2-beat packet 0x11(sop), 0x22(eop).
  -> header_vld with header_data=0x1122, no data_out.valid.
  -> 1-beat packet 0x33(sop+eop) -> err pulse, header_data stays 0x1122.
- Config 8/16, 6-beat packet with data_out.ready toggling 1,0,0,1,...
  -> no beat lost or duplicated.
  -> data_out.data stable while stalled; data_in.ready low while the entry is full and out.ready=0.
- Config 8/16; sop asserted on payload beat 3 of a packet.
  -> err pulse; that beat becomes header slice 0 and the following beat completes a new header.
  -> Loopback: header_adder -> header_stripper with header 0xFFFF and payload 0..9 -> identical header and payload recovered.
- Config 8/16; rst_n asserted mid-payload.
  -> all outputs 0 immediately; the next sop packet is parsed correctly.

Source files
------------

// File: rtl/header_pkg.sv
// Types and helpers shared by the header_adder / header_stripper pair.
package header_pkg;

  typedef enum logic [1:0] {
    S_WAIT_SOP,
    S_HDR,
    S_PAYLOAD
  } hdr_state_e;

  function automatic int unsigned hdr_beats(input int unsigned header_size,
                                            input int unsigned data_width);
    return header_size / data_width;
  endfunction

endpackage

// File: rtl/avalon_st_reg_slice.sv
// One-entry registered Avalon-ST stage; the entry holds while out_valid && !out_ready.
module avalon_st_reg_slice #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_sop  <= in_sop;
        out_eop  <= in_eop;
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/header_stripper.sv
// Strips a HEADER_SIZE-bit header off an Avalon-ST packet, presents it in parallel,
// and forwards the payload as a new packet through a registered output entry.
module header_stripper
  import header_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned HEADER_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  input  logic                   data_in_sop,
  input  logic                   data_in_eop,
  input  logic [DATA_WIDTH-1:0]  data_in_data,
  output logic [HEADER_SIZE-1:0] header_data,
  output logic                   header_vld,
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic                   data_out_sop,
  output logic                   data_out_eop,
  output logic [DATA_WIDTH-1:0]  data_out_data,
  output logic                   err
);

  localparam int unsigned   HDR_BEATS = hdr_beats(HEADER_SIZE, DATA_WIDTH);
  localparam int unsigned   CW        = $clog2(HDR_BEATS + 1);
  localparam logic [CW-1:0] LAST      = CW'(HDR_BEATS - 1);

  if (HEADER_SIZE == 0 || (HEADER_SIZE % DATA_WIDTH) != 0) begin : g_bad_cfg
    $error("header_stripper: HEADER_SIZE must be a non-zero multiple of DATA_WIDTH");
  end

  hdr_state_e             state, state_n;
  logic [CW-1:0]          cnt, cnt_n, pos;
  logic [HEADER_SIZE-1:0] hdr_buf, hdr_buf_n, header_n;
  logic                   vld_n, err_n, first_flag, first_n, fwd;
  logic                   accept, slice_ready;

  assign data_in_ready = (state == S_PAYLOAD) ? slice_ready : 1'b1;
  assign accept        = data_in_valid && data_in_ready;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hdr_buf_n = hdr_buf;
    header_n  = header_data;
    vld_n     = 1'b0;
    err_n     = 1'b0;
    first_n   = first_flag;
    fwd       = 1'b0;
    pos       = '0;
    if (accept) begin
      if (state == S_PAYLOAD && !data_in_sop) begin
        fwd     = 1'b1;
        first_n = 1'b0;
        if (data_in_eop) state_n = S_WAIT_SOP;
      end else if (state == S_WAIT_SOP && !data_in_sop) begin
        err_n = 1'b1;
      end else begin
        // Header beat; a sop anywhere restarts collection at slice 0.
        if (data_in_sop) begin
          pos = '0;
          if (state != S_WAIT_SOP) err_n = 1'b1;
        end else begin
          pos = cnt;
        end
        for (int unsigned i = 0; i < HDR_BEATS; i++) begin
          if (CW'(i) == pos)
            hdr_buf_n[(HDR_BEATS-1-i)*DATA_WIDTH +: DATA_WIDTH] = data_in_data;
        end
        if (pos == LAST) begin
          header_n = hdr_buf_n;
          vld_n    = 1'b1;
          cnt_n    = '0;
          first_n  = 1'b1;
          state_n  = data_in_eop ? S_WAIT_SOP : S_PAYLOAD;
        end else if (data_in_eop) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = S_WAIT_SOP;
        end else begin
          cnt_n   = pos + 1'b1;
          state_n = S_HDR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_WAIT_SOP;
      cnt         <= '0;
      hdr_buf     <= '0;
      header_data <= '0;
      header_vld  <= 1'b0;
      err         <= 1'b0;
      first_flag  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      hdr_buf     <= hdr_buf_n;
      header_data <= header_n;
      header_vld  <= vld_n;
      err         <= err_n;
      first_flag  <= first_n;
    end
  end

  avalon_st_reg_slice #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (fwd),
    .in_ready (slice_ready),
    .in_sop   (first_flag),
    .in_eop   (data_in_eop),
    .in_data  (data_in_data),
    .out_valid(data_out_valid),
    .out_ready(data_out_ready),
    .out_sop  (data_out_sop),
    .out_eop  (data_out_eop),
    .out_data (data_out_data)
  );

endmodule
